// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit adder: CHUNK bits per cycle with a registered inter-chunk carry.
// Optional subtract mode is enabled by defining SEQ_CHUNK_ADDER_SUB_EN (adds port sub).
module seq_chunk_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SEQ_CHUNK_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [NCHUNK-1:0][CHUNK-1:0] a_r, b_r, sum_r;
  logic [CW-1:0]                cnt;
  logic                         carry, cout_r, ovf_r;
  logic                         sub_i, accept, last;
  logic [CHUNK:0]               csum;

`ifdef SEQ_CHUNK_ADDER_SUB_EN
  assign sub_i = sub;
`else
  assign sub_i = 1'b0;
`endif

  assign accept = in_valid & in_ready;
  assign last   = (cnt == CW'(NCHUNK - 1));
  assign csum   = {1'b0, a_r[cnt]} + {1'b0, b_r[cnt]} + {{CHUNK{1'b0}}, carry};

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last)   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs; in_ready in DONE follows out_ready so a drain and a new accept share one edge
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    begin out_valid = 1'b1; in_ready = out_ready; end
      default: ;
    endcase
  end

  // datapath; sum/cout/ovf are written only in RUN so they hold through back-pressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      sum_r  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (accept) begin
      a_r   <= a;
      b_r   <= sub_i ? ~b : b;
      carry <= sub_i ? 1'b1 : cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      sum_r[cnt] <= csum[CHUNK-1:0];
      carry      <= csum[CHUNK];
      cnt        <= cnt + CW'(1);
      if (last) begin
        cout_r <= csum[CHUNK];
        ovf_r  <= (a_r[NCHUNK-1][CHUNK-1] == b_r[NCHUNK-1][CHUNK-1]) &
                  (csum[CHUNK-1] != a_r[NCHUNK-1][CHUNK-1]);
      end
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;
endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
- Parametrised multi-cycle adder for the FPU datapath (mantissa/exponent arithmetic).
- Adds two WIDTH-bit operands CHUNK bits per cycle, with a registered carry between chunks.
- Valid/ready handshake on both the input and output sides.
- Successor to the single-bit half/full-adder cells: generalised width, sequential carry propagation, flags and flow control.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits added per cycle; NCHUNK = WIDTH/CHUNK (NCHUNK ≥ 1).

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry in
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  registered result
- cout  output  1  carry out of MSB
- ovf  output  1  signed (two's-complement) overflow

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; chunk counter, carry, operand regs, sum, cout, ovf = 0; out_valid=0.
  - in_ready=1 once rst_n deasserts.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - RUN: in_ready=0, out_valid=0.
  - DONE: out_valid=1; in_ready=out_ready (combinational).
- Accept: in_valid & in_ready at a rising edge.
  - Latch a, b, cin into internal registers; carry<=cin, cnt<=0; go to RUN.
  - Accept is legal from IDLE, or from DONE in the same cycle that out_ready=1.
- RUN, each cycle:
  - {carry, sum[cnt*CHUNK +: CHUNK]} <= a_r chunk + b_r chunk + carry; cnt<=cnt+1.
  - On the chunk cnt=NCHUNK-1: cout<=carry-out; ovf<=(a_r[MSB]==b_r[MSB]) & (new sum MSB != a_r[MSB]); go to DONE.
- Latency: out_valid rises exactly NCHUNK cycles after the accepting edge. NCHUNK=1 gives a single RUN cycle.
- DONE:
  - sum, cout and ovf are held stable while out_valid=1 and out_ready=0, for any duration.
  - out_ready=1 & in_valid=0 → IDLE.
  - out_ready=1 & in_valid=1 → RUN with the new operands (back-to-back; throughput one op per NCHUNK+1 cycles).
- Result bits:
  - sum/cout/ovf change only during RUN.
  - Chunks of sum not yet written in RUN hold their previous values; sum is only meaningful while out_valid=1.
- Inputs a/b/cin are don't-care outside the accept edge.
- Reset mid-RUN or mid-DONE: immediate abort, result discarded, all state cleared, no spurious out_valid.
- Simultaneous in_valid in RUN: ignored (in_ready=0); the source must hold its operands.

Optional Feature:
- Macro SEQ_CHUNK_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled on the accept edge.
  - sub=1 computes a − b as a + ~b + 1: b_r<=~b, carry<=1, cin ignored. cout=1 means no borrow. ovf uses the inverted b_r MSB.
  - sub=0 behaves as pure add.
- Undefined: port sub absent; always a + b + cin.

Test Plan:
- Reset, WIDTH=32, CHUNK=8: hold rst_n=0 then release → out_valid=0, in_ready=1, sum=0, cout=0, ovf=0.
- Carry ripple: a=0xFFFFFFFF, b=0x00000001, cin=0 → sum=0x00000000, cout=1, ovf=0. out_valid high exactly 4 cycles after accept; in_ready=0 during RUN.
- Add with carry in: a=0x12345678, b=0x11111111, cin=1 → sum=0x2345678A, cout=0. Signed overflow: a=0x7FFFFFFF, b=0x00000001 → sum=0x80000000, cout=0, ovf=1.
- Back-pressure and back-to-back:
  - Hold out_ready=0 for 5 cycles in DONE → out_valid, sum and flags stable; in_ready=0.
  - Then out_ready=1 with in_valid=1 (a=3, b=4) → new op accepted that cycle; next result sum=7 after 4 cycles.
- Reset mid-op: assert rst_n=0 after 2 RUN cycles → out_valid=0 and state IDLE immediately. Next op a=1, b=2 → sum=3 with correct latency.
- SEQ_CHUNK_ADDER_SUB_EN:
  - a=5, b=7, sub=1 → sum=0xFFFFFFFE, cout=0, ovf=0.
  - a=0x80000000, b=1, sub=1 → sum=0x7FFFFFFF, cout=1, ovf=1.
